// File: rtl/pcs_10g_pkg.sv
// Shared widths, sync-header constants and bit-ordering helper for the 10G PCS gearbox.
package pcs_10g_pkg;

  localparam int SERDES_W  = 16;
  localparam int BLOCK_W   = 66;
  localparam int PAYLOAD_W = 64;
  localparam int BUF_W     = 82;
  localparam int CNT_W     = 7;

  typedef logic [1:0] sync_hdr_t;

  localparam sync_hdr_t SH_DATA = 2'b01;
  localparam sync_hdr_t SH_CTRL = 2'b10;

  // Serial order on the wire: header bit 64, header bit 65, then payload bit 0 upward.
  function automatic logic [BLOCK_W-1:0] tx_bit_order(input logic [BLOCK_W-1:0] blk);
    return {blk[PAYLOAD_W-1:0], blk[BLOCK_W-1], blk[BLOCK_W-2]};
  endfunction

endpackage

// File: rtl/pcs_10g_tx_hdr_fifo.sv
// Two-entry FIFO of sync headers awaiting their block's first TX word.
module pcs_10g_tx_hdr_fifo
  import pcs_10g_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  sync_hdr_t push_data_i,
  input  logic      pop_i,
  output sync_hdr_t head_o,
  output logic      empty_o
);

  sync_hdr_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_q ^ push_ok;
      rd_ptr_q <= rd_ptr_q ^ pop_ok;
      count_q  <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/pcs_10g_tx_gearbox.sv
// 10GBASE-R TX gearbox: 66-bit blocks in, 16-bit SERDES words out (bit 0 first).
// Define PCS_TX_SEP_HEADER_EN for separate TXHEADER/TXDATA with an external-gearbox sequence.
module pcs_10g_tx_gearbox
  import pcs_10g_pkg::*;
#(
  parameter int SEQ_MAX          = 32,
  parameter bit UNDERFLOW_STICKY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BLOCK_W-1:0]  tx_block,
  input  logic                tx_block_valid,
  output logic                tx_block_ready,
  output logic [SERDES_W-1:0] tx_data,
  output logic                tx_data_valid,
  output logic [1:0]          tx_header,
  output logic                tx_header_valid,
  output logic [5:0]          tx_sequence,
  output logic                tx_underflow
);

  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(SERDES_W);

  logic [BUF_W-1:0]    buf_q, buf_d, buf_shifted, load_bits;
  logic [CNT_W-1:0]    cnt_q, cnt_d, post_cnt;
  logic                started_q;
  logic [SERDES_W-1:0] tx_data_q;
  logic                tx_data_valid_q;
  logic                tx_underflow_q;
  logic                emit, pause, ready, accept, underflow_d;

`ifdef PCS_TX_SEP_HEADER_EN
  localparam logic [CNT_W-1:0] LOAD_BITS = CNT_W'(PAYLOAD_W);
  localparam logic [5:0]       SEQ_LAST  = 6'(SEQ_MAX);

  logic [5:0] seq_q, seq_d, tx_seq_q;
  logic [1:0] word_idx_q;
  sync_hdr_t  hdr_q, fifo_head;
  logic       hdr_valid_q, fifo_empty, hdr_pop;

  // Buffer carries payload only; headers travel beside it in the FIFO.
  assign load_bits = {{(BUF_W-PAYLOAD_W){1'b0}}, tx_block[PAYLOAD_W-1:0]};
  assign pause     = started_q && (seq_q == SEQ_LAST);
  assign hdr_pop   = emit && (word_idx_q == 2'd0) && !fifo_empty;
  assign seq_d     = (!started_q || (seq_q == SEQ_LAST)) ? 6'd0 : seq_q + 6'd1;

  pcs_10g_tx_hdr_fifo u_hdr_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (tx_block[BLOCK_W-1:PAYLOAD_W]),
    .pop_i       (hdr_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q       <= 6'd0;
      tx_seq_q    <= 6'd0;
      word_idx_q  <= 2'd0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      tx_seq_q    <= seq_q;
      hdr_valid_q <= hdr_pop;
      hdr_q       <= hdr_pop ? fifo_head : '0;
      if (emit) word_idx_q <= word_idx_q + 2'd1;
    end
  end

  assign tx_header       = hdr_q;
  assign tx_header_valid = hdr_valid_q;
  assign tx_sequence     = tx_seq_q;
`else
  localparam logic [CNT_W-1:0] LOAD_BITS = CNT_W'(BLOCK_W);

  logic unused_seq_cfg;

  assign load_bits       = {{(BUF_W-BLOCK_W){1'b0}}, tx_bit_order(tx_block)};
  assign pause           = 1'b0;
  assign unused_seq_cfg  = (SEQ_MAX > 63);
  assign tx_header       = 2'b00;
  assign tx_header_valid = 1'b0;
  assign tx_sequence     = 6'd0;
`endif

  // Bits above cnt_q are always zero, so a new block can simply be OR-ed in.
  always_comb begin
    emit        = (cnt_q >= WORD_BITS) && !pause;
    post_cnt    = emit ? (cnt_q - WORD_BITS) : cnt_q;
    ready       = (post_cnt <= WORD_BITS);
    accept      = tx_block_valid && ready;
    buf_shifted = emit ? (buf_q >> SERDES_W) : buf_q;
    buf_d       = accept ? (buf_shifted | (load_bits << post_cnt)) : buf_shifted;
    cnt_d       = accept ? (post_cnt + LOAD_BITS) : post_cnt;
    underflow_d = started_q && !emit && !pause;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q           <= '0;
      cnt_q           <= '0;
      started_q       <= 1'b0;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
      tx_underflow_q  <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      cnt_q           <= cnt_d;
      started_q       <= started_q | accept;
      tx_data_valid_q <= emit;
      tx_underflow_q  <= underflow_d | (UNDERFLOW_STICKY && tx_underflow_q);
      if (emit) tx_data_q <= buf_q[SERDES_W-1:0];
    end
  end

  assign tx_block_ready = ready;
  assign tx_data        = tx_data_q;
  assign tx_data_valid  = tx_data_valid_q;
  assign tx_underflow   = tx_underflow_q;

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Bench for pcs_10g_tx_gearbox: bit-queue reference model feeding a word scoreboard,
// with a second instance built with sticky underflow sharing the same stimulus.
`timescale 1ns/1ps
module tb_pcs_10g_tx_gearbox;
  import pcs_10g_pkg::*;

  localparam int SEQ_MAX = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [BLOCK_W-1:0] tx_block = '0;
  logic               tx_block_valid = 1'b0;

  logic                tx_block_ready, tx_data_valid, tx_header_valid, tx_underflow;
  logic [SERDES_W-1:0] tx_data;
  logic [1:0]          tx_header;
  logic [5:0]          tx_sequence;
  logic                st_ready, st_data_valid, st_header_valid, st_underflow;
  logic [SERDES_W-1:0] st_data;
  logic [1:0]          st_header;
  logic [5:0]          st_sequence;

  always #5 clk = ~clk;

  pcs_10g_tx_gearbox #(.SEQ_MAX(SEQ_MAX), .UNDERFLOW_STICKY(1'b0)) u_dut (
    .clk(clk), .rst(rst), .tx_block(tx_block), .tx_block_valid(tx_block_valid),
    .tx_block_ready(tx_block_ready), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_header(tx_header), .tx_header_valid(tx_header_valid), .tx_sequence(tx_sequence),
    .tx_underflow(tx_underflow)
  );

  pcs_10g_tx_gearbox #(.SEQ_MAX(SEQ_MAX), .UNDERFLOW_STICKY(1'b1)) u_sticky (
    .clk(clk), .rst(rst), .tx_block(tx_block), .tx_block_valid(tx_block_valid),
    .tx_block_ready(st_ready), .tx_data(st_data), .tx_data_valid(st_data_valid),
    .tx_header(st_header), .tx_header_valid(st_header_valid), .tx_sequence(st_sequence),
    .tx_underflow(st_underflow)
  );

  // Reference model: the serial stream as a queue of bits.
  bit          bq[$];
  logic [1:0]  hq[$];
  logic [15:0] exp_words[$];
  logic [15:0] cap[$];
  bit          m_started;
  int          m_seq, m_widx;
  bit          exp_dv, exp_uf, exp_uf_st, exp_hv;
  logic [1:0]  exp_hdr;
  int          exp_seq;
  bit          mon_en = 1'b0;
  bit          cap_en = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          acc_cnt = 0;
  int          word_cnt = 0;
  int          hv_cnt = 0;

  function automatic bit m_pause();
`ifdef PCS_TX_SEP_HEADER_EN
    return m_started && (m_seq == SEQ_MAX);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_emit();
    return (bq.size() >= SERDES_W) && !m_pause();
  endfunction

  function automatic bit m_ready();
    int post;
    post = bq.size() - (m_emit() ? SERDES_W : 0);
    return post <= SERDES_W;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit          emit, acc, pause;
    logic [15:0] w;
    if (rst) begin
      bq.delete(); hq.delete(); exp_words.delete();
      m_started = 1'b0; m_seq = 0; m_widx = 0;
      exp_dv = 1'b0; exp_uf = 1'b0; exp_uf_st = 1'b0;
      exp_hv = 1'b0; exp_hdr = 2'b00; exp_seq = 0;
    end else begin
      pause     = m_pause();
      emit      = m_emit();
      acc       = tx_block_valid && m_ready();
      exp_dv    = emit;
      exp_uf    = m_started && !emit && !pause;
      exp_uf_st = exp_uf_st | exp_uf;
      exp_hv    = 1'b0;
      exp_hdr   = 2'b00;
      exp_seq   = m_seq;
      if (emit) begin
        for (int i = 0; i < SERDES_W; i++) w[i] = bq.pop_front();
        exp_words.push_back(w);
`ifdef PCS_TX_SEP_HEADER_EN
        if (m_widx == 0 && hq.size() > 0) begin
          exp_hv  = 1'b1;
          exp_hdr = hq.pop_front();
        end
`endif
        m_widx = (m_widx + 1) % 4;
      end
      if (acc) begin
`ifdef PCS_TX_SEP_HEADER_EN
        hq.push_back(tx_block[65:64]);
`else
        bq.push_back(tx_block[64]);
        bq.push_back(tx_block[65]);
`endif
        for (int i = 0; i < PAYLOAD_W; i++) bq.push_back(tx_block[i]);
      end
      if (m_started) m_seq = (m_seq == SEQ_MAX) ? 0 : m_seq + 1;
      m_started = m_started | acc;
    end
  end

  // Monitor: one line per transaction (accepted block / emitted word).
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", tx_block_ready, m_ready());
      chk("sticky_ready", st_ready, m_ready());
      chk("underflow", tx_underflow, exp_uf);
      chk("underflow_sticky", st_underflow, exp_uf_st);
      chk("data_valid", tx_data_valid, exp_dv);
      chk("occupancy", u_dut.cnt_q, bq.size());
      if (tx_block_valid && tx_block_ready) begin
        acc_cnt++;
        $display("[TB] accept block 0x%017h", tx_block);
      end
      if (tx_data_valid) begin
        word_cnt++;
        $display("[TB] word 0x%04h", tx_data);
        if (cap_en) cap.push_back(tx_data);
        if (exp_words.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%04h, required no word", tx_data);
        end else begin
          chk("data", tx_data, exp_words.pop_front());
        end
      end
`ifdef PCS_TX_SEP_HEADER_EN
      chk("sequence", tx_sequence, exp_seq);
      chk("header_valid", tx_header_valid, exp_hv);
      if (exp_hv) begin
        hv_cnt++;
        chk("header", tx_header, exp_hdr);
      end
`else
      chk("sep_outputs_tied", {tx_header, tx_header_valid, tx_sequence}, 0);
`endif
    end
  end

  task automatic step(input bit v, input logic [BLOCK_W-1:0] b);
    tx_block_valid = v;
    tx_block       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_block_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] b;
    b[63:0]  = {$urandom, $urandom};
    b[65:64] = ($urandom_range(0, 1) != 0) ? SH_CTRL : SH_DATA;
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLOCK_W-1:0] blk;
    logic [63:0]        p;
    bit                 have, v, take;
    int                 guard;
    int                 rst_at;

    do_reset();
    mon_en = 1'b1;

    // Single block, then idle: header first, 2 residual bits, underflow after 4th word.
    blk = 66'h2_0123456789ABCDEF;
    p   = blk[63:0];
    cap.delete();
    cap_en = 1'b1;
    step(1'b1, blk);
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    cap_en = 1'b0;
`ifndef PCS_TX_SEP_HEADER_EN
    chk("p1_word_count", cap.size(), 4);
    if (cap.size() == 4) begin
      chk("p1_word0", cap[0], {p[13:0], 2'b10});
      chk("p1_word1", cap[1], p[29:14]);
      chk("p1_word2", cap[2], p[45:30]);
      chk("p1_word3", cap[3], p[61:46]);
    end
    chk("p1_residual", u_dut.cnt_q, 2);
`endif

    // Continuous offers: 8 accepts, 33 words, buffer drains.
    do_reset();
    acc_cnt  = 0;
    word_cnt = 0;
    for (int i = 0; i < 32; i++) step(1'b1, rand_block());
    for (int i = 0; i < 6; i++) step(1'b0, '0);
`ifndef PCS_TX_SEP_HEADER_EN
    chk("p2_accepts", acc_cnt, 8);
    chk("p2_words", word_cnt, 33);
    chk("p2_drained", u_dut.cnt_q, 0);
`endif

    // Random valid with backpressure; a refused block is held until taken.
    do_reset();
    have = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        blk  = rand_block();
        have = 1'b1;
      end
      v    = ($urandom_range(0, 3) != 0);
      take = v && tx_block_ready;
      step(v, blk);
      if (take) have = 1'b0;
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    // Reset in mid-stream: nothing stale survives.
`ifdef PCS_TX_SEP_HEADER_EN
    rst_at = 48;
`else
    rst_at = 50;
`endif
    do_reset();
    step(1'b1, rand_block());
    guard = 0;
    while ((int'(u_dut.cnt_q) != rst_at) && (guard < 10)) begin
      step(1'b0, '0);
      guard++;
    end
    chk("p4_reach_target", u_dut.cnt_q, rst_at);
    rst = 1'b1;
    step(1'b0, '0);
    chk("p4_rst_data", tx_data, 0);
    chk("p4_rst_valid", tx_data_valid, 0);
    chk("p4_rst_underflow", tx_underflow, 0);
    chk("p4_rst_ready", tx_block_ready, 1);
    rst = 1'b0;
    blk = 66'h1_FEDCBA9876543210;
    p   = blk[63:0];
    cap.delete();
    cap_en = 1'b1;
    step(1'b1, blk);
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    cap_en = 1'b0;
    chk("p4_first_word_count", cap.size() >= 1, 1);
    if (cap.size() >= 1) begin
`ifdef PCS_TX_SEP_HEADER_EN
      chk("p4_first_word", cap[0], p[15:0]);
`else
      chk("p4_first_word", cap[0], {p[13:0], 2'b01});
`endif
    end

`ifdef PCS_TX_SEP_HEADER_EN
    // Continuous blocks with the sequence counter and its pause cycle.
    do_reset();
    hv_cnt = 0;
    for (int i = 0; i < 330; i++) step(1'b1, rand_block());
    chk("p5_headers_seen", hv_cnt >= 70, 1);
`endif

    // Sticky underflow: rises after a gap, holds through a resumed stream, clears on reset.
    do_reset();
    step(1'b1, rand_block());
    for (int i = 0; i < 7; i++) step(1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b1, rand_block());
    chk("sticky_held", st_underflow, 1);
    chk("pulse_cleared", tx_underflow, 0);
    do_reset();
    chk("sticky_cleared", st_underflow, 0);

    chk("scoreboard_empty", exp_words.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
